// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone incrementing-burst pattern writer and read-back checker.
module wb_burst_master #(
    parameter int unsigned AW  = 26,
    parameter int unsigned DW  = 32,
    parameter int unsigned TMO = 1023
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [3:0]        cmd_len,
    input  logic [DW-1:0]     cmd_seed,
    input  logic              err_clr,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic [DW-1:0]     wb_dat_i,
    input  logic              wb_ack_i,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_cnt,
    output logic [AW-1:0]     err_addr,
    output logic              timeout
);

    localparam int unsigned SW  = DW / 8;
    localparam int unsigned WDW = 10;
    localparam logic [2:0]  CTI_CLASSIC = 3'b000;
    localparam logic [2:0]  CTI_INCR    = 3'b010;
    localparam logic [2:0]  CTI_END     = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_ready, w_ready;
    logic               r_cyc, w_cyc;
    logic               r_we, w_we;
    logic [AW-1:0]      r_addr, w_addr;
    logic [DW-1:0]      r_dat, w_dat;
    logic [DW-1:0]      r_exp, w_exp;
    logic [SW-1:0]      r_sel, w_sel;
    logic [2:0]         r_cti, w_cti;
    logic [3:0]         r_beat, w_beat;
    logic [3:0]         r_last, w_last;
    logic [WDW-1:0]     r_wdog, w_wdog;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic [15:0]        r_err_cnt, w_err_cnt;
    logic [AW-1:0]      r_err_addr, w_err_addr;
    logic               r_timeout, w_timeout;

    logic               w_ack_last;
    logic               w_wdog_exp;
    logic               w_mismatch;
    logic [3:0]         w_beat_inc;
    logic [DW-1:0]      w_exp_inc;
    logic [AW-1:0]      w_base;

    assign w_ack_last = wb_ack_i && (r_beat == r_last);
    assign w_wdog_exp = !wb_ack_i && (r_wdog == WDW'(TMO - 1));
    assign w_mismatch = wb_ack_i && !r_we && (wb_dat_i != r_exp);
    assign w_beat_inc = r_beat + 4'd1;
    assign w_exp_inc  = r_exp + DW'(1);
    assign w_base     = cmd_addr & ~AW'(3);

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (cmd_valid) w_state_nxt = S_XFER;
            S_XFER: if (w_ack_last || w_wdog_exp) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of all registered outputs and burst datapath
    always_comb begin
        w_ready    = r_ready;
        w_cyc      = r_cyc;
        w_we       = r_we;
        w_addr     = r_addr;
        w_dat      = r_dat;
        w_exp      = r_exp;
        w_sel      = r_sel;
        w_cti      = r_cti;
        w_beat     = r_beat;
        w_last     = r_last;
        w_wdog     = r_wdog;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_err_cnt  = r_err_cnt;
        w_err_addr = r_err_addr;
        w_timeout  = r_timeout;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_ready = 1'b0;
                    w_cyc   = 1'b1;
                    w_we    = cmd_we;
                    w_addr  = w_base;
                    w_exp   = cmd_seed;
                    w_dat   = cmd_we ? cmd_seed : '0;
                    w_sel   = '1;
                    w_cti   = (cmd_len == 4'd1) ? CTI_END : CTI_INCR;
                    w_beat  = 4'd0;
                    w_last  = cmd_len - 4'd1;
                    w_wdog  = '0;
                    w_busy  = 1'b1;
                end
            end
            S_XFER: begin
                if (w_mismatch) begin
                    w_err_cnt = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;
                    if (r_err_cnt == 16'd0) w_err_addr = r_addr;
                end
                if (w_ack_last || w_wdog_exp) begin
                    w_cyc  = 1'b0;
                    w_we   = 1'b0;
                    w_sel  = '0;
                    w_cti  = CTI_CLASSIC;
                    w_done = 1'b1;
                    if (w_wdog_exp) w_timeout = 1'b1;
                end else if (wb_ack_i) begin
                    w_wdog = '0;
                    w_beat = w_beat_inc;
                    w_addr = r_addr + AW'(4);
                    w_exp  = w_exp_inc;
                    w_dat  = r_we ? w_exp_inc : '0;
                    w_cti  = (w_beat_inc == r_last) ? CTI_END : CTI_INCR;
                end else begin
                    w_wdog = r_wdog + WDW'(1);
                end
            end
            S_DONE: begin
                w_busy  = 1'b0;
                w_ready = 1'b1;
            end
            default: begin
                w_busy  = 1'b0;
                w_ready = 1'b1;
            end
        endcase
        // Clearing the error record beats any concurrent update
        if (err_clr) begin
            w_err_cnt  = '0;
            w_err_addr = '0;
            w_timeout  = 1'b0;
        end
    end

    // Output and datapath registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_ready    <= 1'b1;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_dat      <= '0;
            r_exp      <= '0;
            r_sel      <= '0;
            r_cti      <= CTI_CLASSIC;
            r_beat     <= '0;
            r_last     <= '0;
            r_wdog     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err_cnt  <= '0;
            r_err_addr <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_ready    <= w_ready;
            r_cyc      <= w_cyc;
            r_we       <= w_we;
            r_addr     <= w_addr;
            r_dat      <= w_dat;
            r_exp      <= w_exp;
            r_sel      <= w_sel;
            r_cti      <= w_cti;
            r_beat     <= w_beat;
            r_last     <= w_last;
            r_wdog     <= w_wdog;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_err_cnt  <= w_err_cnt;
            r_err_addr <= w_err_addr;
            r_timeout  <= w_timeout;
        end
    end

    assign cmd_ready = r_ready;
    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_cyc;
    assign wb_we_o   = r_we;
    assign wb_addr_o = r_addr;
    assign wb_dat_o  = r_dat;
    assign wb_sel_o  = r_sel;
    assign wb_cti_o  = r_cti;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_cnt   = r_err_cnt;
    assign err_addr  = r_err_addr;
    assign timeout   = r_timeout;

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 Parameter AW, 26, Wishbone byte-address width driven to sdrc_top wb_addr_i.
REQ-002 Parameter DW, 32, Wishbone data width; SEL width = DW/8.
REQ-003 Parameter TMO, 1023, wait-for-ack watchdog limit in cycles, 10-bit counter.
REQ-004 The module SHALL use a single clock and an asynchronous, active-low reset, with ports:
- wb_clk_i  in  1  Wishbone clock, sole clock.
- wb_rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_we  in  1  1 = write burst, 0 = read-and-check burst.
- cmd_addr  in  AW  burst base byte address; bits [1:0] ignored and treated as 0.
- cmd_len  in  4  beats; 1..15 literal, 0 = 16.
- cmd_seed  in  DW  data pattern seed.
- err_clr  in  1  clears err_cnt, err_addr, timeout.
- wb_cyc_o, wb_stb_o  out  1  Wishbone cycle and strobe.
- wb_we_o  out  1  write enable.
- wb_addr_o  out  AW  beat address.
- wb_dat_o  out  DW  write data.
- wb_sel_o  out  DW/8  byte selects.
- wb_cti_o  out  3  cycle type.
- wb_dat_i  in  DW  read data.
- wb_ack_i  in  1  beat acknowledge.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst end.
- err_cnt  out  16  saturating read-mismatch count.
- err_addr  out  AW  address of first mismatch since the last clear.
- timeout  out  1  sticky watchdog flag.

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, XFER, DONE.
REQ-006 In IDLE, cmd_ready SHALL be 1. On cmd_valid, the block SHALL latch we, addr (with [1:0] forced to 0), len, and seed, clear beat counter and watchdog, and enter XFER next cycle.
REQ-007 In XFER, outputs SHALL be registered: wb_cyc_o = wb_stb_o = 1, wb_we_o = latched we, wb_sel_o = all ones.
REQ-008 wb_addr_o SHALL equal base + 4*beat, modulo 2^AW; wrap-around is permitted.
REQ-009 For writes, wb_dat_o SHALL equal seed + beat, modulo 2^DW. For reads, wb_dat_o SHALL be 0.
REQ-010 wb_cti_o SHALL be 3'b010 on every beat except the last; the last beat SHALL drive 3'b111. A 1-beat burst SHALL drive 3'b111 only.
REQ-011 A beat SHALL complete on any cycle with wb_ack_i = 1 in XFER. On that edge, beat increments and the address/data/cti for the next beat appear on the following cycle.
REQ-012 wb_ack_i outside XFER SHALL be ignored.
REQ-013 On a read-beat ack, if wb_dat_i != seed + beat, the block SHALL increment err_cnt, saturating at 16'hFFFF.
REQ-014 On such a mismatch, if err_cnt was 0, the block SHALL load err_addr with the beat address.
REQ-015 After the last-beat ack, the block SHALL enter DONE. wb_cyc_o and wb_stb_o SHALL be 0 in DONE and IDLE; wb_cti_o SHALL be 3'b000 in both.
REQ-016 In XFER, the watchdog SHALL increment each cycle without ack and clear on ack. On reaching TMO, the block SHALL set timeout, drop cyc/stb, and enter DONE without further beats.
REQ-017 DONE SHALL last one cycle with done = 1, then return to IDLE. busy SHALL be 1 in XFER and DONE.
REQ-018 cmd_ready SHALL be 0 in XFER and DONE, and cmd_valid SHALL be ignored in those states.
REQ-019 err_clr SHALL take effect in any state. If err_clr coincides with a mismatch, the clear SHALL win.

Reset
REQ-020 Asserting wb_rst_n low SHALL immediately, without a clock, force IDLE and drive these outputs to 0: cyc, stb, we, addr, dat, sel, cti, busy, done, err_cnt, err_addr, timeout. cmd_ready SHALL then be 1.
REQ-021 Reset mid-burst SHALL abandon the burst with no done pulse. The first command after reset release SHALL behave normally.

Verification
REQ-022 Write of len=8, addr=0x100, seed=0xA5A50000, ack every cycle -> addresses 0x100..0x11C step 4, data 0xA5A50000..0xA5A50007, cti 010 x7 then 111, done one cycle after the 8th ack.
REQ-023 Read of the same burst against sdrc_top with the SDRAM model after the write -> err_cnt = 0, timeout = 0.
REQ-024 Read with seed=0x00000000 over the same data -> err_cnt = 8, err_addr = 0x100; err_clr -> both return to 0.
REQ-025 len=1 at addr=0x3FFFFFC with wb_ack_i tied 0 -> single beat with cti 111, timeout = 1 after 1023 cycles, done pulse, cyc = 0.
REQ-026 wb_rst_n low during beat 3 of a 16-beat (len=0) write -> cyc/stb = 0 asynchronously, no done. A following len=2 write -> completes normally with cmd_valid held during the burst ignored.
